// File: rtl/regfile_pkg.sv
// Shared helpers for the multiport register file: sizing and write-port priority.
// Pure functions and constants, no state.
package regfile_pkg;

  // Widest write-port vector the priority helper accepts.
  localparam int MAX_WP = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int regs_of(input int aw);
    return 1 << aw;
  endfunction

  // One-hot of the highest set enable: the highest port index wins a conflict.
  function automatic logic [MAX_WP-1:0] prio_onehot(input logic [MAX_WP-1:0] en);
    logic [MAX_WP-1:0] oh;
    oh = '0;
    for (int k = 0; k < MAX_WP; k++) begin
      if (en[k]) oh = MAX_WP'(1) << k;
    end
    return oh;
  endfunction

endpackage

// File: rtl/regfile_wrarb.sv
// Per-entry write arbiter: picks the highest-index requesting port, flags the losers.
// Purely combinational, never stalls.
module regfile_wrarb
  import regfile_pkg::*;
#(
  parameter int WP = 3,
  parameter int RW = 16
) (
  input  logic [WP-1:0]    en,
  input  logic [WP*RW-1:0] data,
  output logic             we,
  output logic [RW-1:0]    wdata,
  output logic [WP-1:0]    lost
);

  logic [WP-1:0] win;

  assign win  = WP'(prio_onehot(MAX_WP'(en)));
  assign we   = |en;
  assign lost = en & ~win;

  always_comb begin
    wdata = '0;
    for (int j = 0; j < WP; j++) begin
      if (win[j]) wdata = data[j*RW +: RW];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multiport register file: WP prioritised writes, RP reads with optional bypass and output register.
// Write latency 1, read latency RDREG; no backpressure, every request accepted every cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int AW     = 6,
  parameter int RW     = 16,
  parameter int RP     = 5,
  parameter int WP     = 3,
  parameter int RDREG  = 1,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [WP-1:0]     wr_valid,
  input  logic [WP*AW-1:0]  wr_addr,
  input  logic [WP*RW-1:0]  wr_data,
  output logic [WP-1:0]     wr_lost,
  input  logic [RP-1:0]     rd_valid,
  input  logic [RP*AW-1:0]  rd_addr,
  output logic [RP*RW-1:0]  rd_data,
  output logic [RP-1:0]     rd_vld,
  output logic [RP-1:0]     rd_written,
  output logic [2**AW-1:0]  status
);

  localparam int REGS = regs_of(AW);

  logic [RW-1:0]   mem       [REGS];
  logic [REGS-1:0] ent_we;
  logic [RW-1:0]   ent_wdata [REGS];
  logic [WP-1:0]   ent_lost  [REGS];
  logic [WP-1:0]   lost_any;

  for (genvar i = 0; i < REGS; i++) begin : g_ent
    logic [WP-1:0] en;
    logic [RW-1:0] q;
    logic          wr_q;

    always_comb begin
      en = '0;
      for (int j = 0; j < WP; j++) begin
        en[j] = wr_valid[j] && (wr_addr[j*AW +: AW] == AW'(i));
      end
    end

    regfile_wrarb #(.WP(WP), .RW(RW)) u_arb (
      .en    (en),
      .data  (wr_data),
      .we    (ent_we[i]),
      .wdata (ent_wdata[i]),
      .lost  (ent_lost[i])
    );

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        q    <= '0;
        wr_q <= 1'b0;
      end else if (ent_we[i]) begin
        q    <= ent_wdata[i];
        wr_q <= 1'b1;
      end
    end

    assign mem[i]    = q;
    assign status[i] = wr_q;
  end

  // A port addresses only one entry, so OR-ing across entries yields its lost flag.
  always_comb begin
    lost_any = '0;
    for (int i = 0; i < REGS; i++) lost_any |= ent_lost[i];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) wr_lost <= '0;
    else         wr_lost <= lost_any;
  end

  for (genvar r = 0; r < RP; r++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    logic [RW-1:0] val;
    logic          wrn;

    assign ra  = rd_addr[r*AW +: AW];
    assign hit = (BYPASS != 0) && ent_we[ra];
    assign val = {RW{rd_valid[r]}} & (hit ? ent_wdata[ra] : mem[ra]);
    assign wrn = rd_valid[r] & (hit | status[ra]);

    if (RDREG != 0) begin : g_reg
      logic [RW-1:0] data_q;
      logic          vld_q;
      logic          wrn_q;

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          data_q <= '0;
          vld_q  <= 1'b0;
          wrn_q  <= 1'b0;
        end else begin
          data_q <= val;
          vld_q  <= rd_valid[r];
          wrn_q  <= wrn;
        end
      end

      assign rd_data[r*RW +: RW] = data_q;
      assign rd_vld[r]           = vld_q;
      assign rd_written[r]       = wrn_q;
    end else begin : g_comb
      assign rd_data[r*RW +: RW] = val;
      assign rd_vld[r]           = rd_valid[r];
      assign rd_written[r]       = wrn;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: four instances covering every RDREG/BYPASS combination on shared stimulus.
module tb_regfile_mp;

  localparam int AW   = 6;
  localparam int RW   = 16;
  localparam int RP   = 5;
  localparam int WP   = 3;
  localparam int REGS = 64;
  localparam int NDUT = 4;

  typedef struct {
    int          dut;
    int          port;
    logic [15:0] data;
    logic        vld;
    logic        wrn;
  } exp_t;

  logic             clk = 1'b0;
  logic             nreset;
  logic [WP-1:0]    wr_valid;
  logic [WP*AW-1:0] wr_addr;
  logic [WP*RW-1:0] wr_data;
  logic [RP-1:0]    rd_valid;
  logic [RP*AW-1:0] rd_addr;

  logic [WP-1:0]    wr_lost_w    [NDUT];
  logic [RP*RW-1:0] rd_data_w    [NDUT];
  logic [RP-1:0]    rd_vld_w     [NDUT];
  logic [RP-1:0]    rd_written_w [NDUT];
  logic [REGS-1:0]  status_w     [NDUT];

  exp_t            sb[$];
  logic [RW-1:0]   m_mem [REGS];
  logic [REGS-1:0] m_status;
  int              n_cmp = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  // Instance g: RDREG = g%2, BYPASS = g/2.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    regfile_mp #(
      .AW(AW), .RW(RW), .RP(RP), .WP(WP), .RDREG(g % 2), .BYPASS(g / 2)
    ) u_dut (
      .clk        (clk),
      .nreset     (nreset),
      .wr_valid   (wr_valid),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_lost    (wr_lost_w[g]),
      .rd_valid   (rd_valid),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data_w[g]),
      .rd_vld     (rd_vld_w[g]),
      .rd_written (rd_written_w[g]),
      .status     (status_w[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_rd(input exp_t e);
    check($sformatf("rd_data d%0d p%0d", e.dut, e.port),
          64'(rd_data_w[e.dut][e.port*RW +: RW]), 64'(e.data));
    check($sformatf("rd_vld d%0d p%0d", e.dut, e.port),
          64'(rd_vld_w[e.dut][e.port]), 64'(e.vld));
    check($sformatf("rd_written d%0d p%0d", e.dut, e.port),
          64'(rd_written_w[e.dut][e.port]), 64'(e.wrn));
  endtask

  task automatic idle();
    wr_valid = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_valid = '0;
    rd_addr  = '0;
  endtask

  task automatic set_wr(input int j, input int a, input logic [15:0] d);
    wr_valid[j]          = 1'b1;
    wr_addr[j*AW +: AW]  = AW'(a);
    wr_data[j*RW +: RW]  = d;
  endtask

  task automatic set_rd(input int r, input int a);
    rd_valid[r]         = 1'b1;
    rd_addr[r*AW +: AW] = AW'(a);
  endtask

  task automatic model_reset();
    for (int i = 0; i < REGS; i++) m_mem[i] = '0;
    m_status = '0;
    sb.delete();
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic do_cycle();
    logic [WP-1:0] exp_lost;
    #1;
    for (int r = 0; r < RP; r++) begin
      logic [AW-1:0] ra;
      int            win;
      ra  = rd_addr[r*AW +: AW];
      win = -1;
      for (int j = 0; j < WP; j++)
        if (wr_valid[j] && wr_addr[j*AW +: AW] == ra) win = j;
      for (int g = 0; g < NDUT; g++) begin
        exp_t e;
        e.dut  = g;
        e.port = r;
        e.vld  = rd_valid[r];
        if (g / 2 == 1 && win >= 0) begin
          e.data = wr_data[win*RW +: RW];
          e.wrn  = 1'b1;
        end else begin
          e.data = m_mem[ra];
          e.wrn  = m_status[ra];
        end
        if (!rd_valid[r]) begin
          e.data = '0;
          e.wrn  = 1'b0;
        end
        if (g % 2 == 0) check_rd(e);
        else            sb.push_back(e);
      end
    end
    exp_lost = '0;
    for (int j = 0; j < WP; j++)
      for (int k = j + 1; k < WP; k++)
        if (wr_valid[j] && wr_valid[k] && wr_addr[j*AW +: AW] == wr_addr[k*AW +: AW])
          exp_lost[j] = 1'b1;
    @(posedge clk);
    for (int j = 0; j < WP; j++) begin
      if (wr_valid[j]) begin
        m_mem[wr_addr[j*AW +: AW]]    = wr_data[j*RW +: RW];
        m_status[wr_addr[j*AW +: AW]] = 1'b1;
      end
    end
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("wr_lost d%0d", g), 64'(wr_lost_w[g]), 64'(exp_lost));
      check($sformatf("status d%0d", g), 64'(status_w[g]), 64'(m_status));
    end
    while (sb.size() > 0) check_rd(sb.pop_front());
    @(negedge clk);
  endtask

  initial begin
    idle();
    nreset = 1'b0;
    model_reset();
    #3;
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("rst wr_lost d%0d", g), 64'(wr_lost_w[g]), 64'(0));
      check($sformatf("rst status d%0d", g), 64'(status_w[g]), 64'(0));
      check($sformatf("rst rd_data d%0d", g), 64'(rd_data_w[g]), 64'(0));
      check($sformatf("rst rd_vld d%0d", g), 64'(rd_vld_w[g]), 64'(0));
    end
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;

    // Never-written entry reads as zero, not written.
    idle(); set_rd(0, 63); do_cycle();

    // Parallel writes to distinct entries, then read them back.
    idle(); set_wr(0, 1, 16'h000A); set_wr(1, 2, 16'h000B); set_wr(2, 3, 16'h000C);
    set_rd(0, 1); set_rd(1, 2); set_rd(2, 3); do_cycle();
    idle(); set_rd(0, 1); set_rd(1, 2); set_rd(2, 3); do_cycle();

    // Three-way conflict on entry 7; wr_lost then clears.
    idle(); set_wr(0, 7, 16'h1111); set_wr(1, 7, 16'h2222); set_wr(2, 7, 16'h3333);
    set_rd(4, 7); do_cycle();
    idle(); set_rd(4, 7); do_cycle();

    // Same-cycle write/read of entry 9.
    idle(); set_wr(0, 9, 16'h00FF); do_cycle();
    idle(); set_wr(0, 9, 16'hABCD); set_rd(4, 9); do_cycle();
    idle(); set_rd(4, 9); do_cycle();

    // Partial rd_valid, all ports on entry 3.
    idle(); rd_valid = 5'b10101;
    for (int r = 0; r < RP; r++) rd_addr[r*AW +: AW] = AW'(3);
    do_cycle();

    // Writing zero still marks the entry written.
    idle(); set_wr(1, 63, 16'h0000); do_cycle();
    idle(); set_rd(2, 63); do_cycle();

    // Random traffic on a narrow address window to provoke conflicts and bypass hits.
    for (int n = 0; n < 24; n++) begin
      idle();
      for (int j = 0; j < WP; j++)
        if ($urandom_range(0, 1) == 1) set_wr(j, int'($urandom_range(0, 7)), 16'($urandom));
      for (int r = 0; r < RP; r++)
        if ($urandom_range(0, 1) == 1) set_rd(r, int'($urandom_range(0, 7)));
      do_cycle();
    end

    // Leave wr_lost and the read registers non-zero, then clear asynchronously.
    idle(); set_wr(0, 5, 16'h1234); set_wr(1, 5, 16'hBEEF); set_rd(1, 3); do_cycle();
    idle(); set_rd(1, 5);
    #1;
    check("pre-rst comb read 5", 64'(rd_data_w[0][1*RW +: RW]), 64'(16'hBEEF));
    #1;
    nreset = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("async wr_lost d%0d", g), 64'(wr_lost_w[g]), 64'(0));
      check($sformatf("async status d%0d", g), 64'(status_w[g]), 64'(0));
      check($sformatf("async rd_written d%0d", g), 64'(rd_written_w[g]), 64'(0));
      check($sformatf("async rd_data d%0d", g), 64'(rd_data_w[g]), 64'(0));
    end
    check("async rd_vld d1", 64'(rd_vld_w[1]), 64'(0));
    check("async rd_vld d3", 64'(rd_vld_w[3]), 64'(0));
    #1;
    nreset = 1'b1;
    model_reset();
    @(negedge clk);
    idle(); set_rd(0, 5); do_cycle();
    idle(); do_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
